// File: rtl/seg7_scan_decoder.sv
// Receiver for a multiplexed 7-segment bus: waits for each digit's pattern to settle,
// decodes it back to hex and flags blank/error/dp per digit, pulsing once per full frame.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 3,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      input_clock1_1,
    input  logic                      input_reset_n_2,
    input  logic [7:0]                input_segments_3,
    input  logic [NUM_DIGITS-1:0]     input_digit_sel_4,
    output logic [4*NUM_DIGITS-1:0]   output_value_5,
    output logic [NUM_DIGITS-1:0]     output_dp_6,
    output logic [NUM_DIGITS-1:0]     output_valid_7,
    output logic [NUM_DIGITS-1:0]     output_blank_8,
    output logic [NUM_DIGITS-1:0]     output_error_9,
    output logic                      output_frame_10
);

    localparam logic [7:0] CntFull = 8'(STABLE_CYCLES);
    localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCounting, StLocked} state_e;

    state_e                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]     sel_q, sel_prev_q;
    logic [7:0]                seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]     mask_q;
    logic [4*NUM_DIGITS-1:0]   value_q;
    logic [NUM_DIGITS-1:0]     dp_q, valid_q, blank_q, error_q;
    logic                      frame_q;

    logic                      sel_onehot, same, commit;
    logic [NUM_DIGITS-1:0]     mask_set;
    logic                      mask_full;
    logic [6:0]                letters;
    logic [3:0]                dec_value;
    logic                      dec_blank, dec_error;

    assign sel_onehot = $onehot(sel_q);
    assign same       = (sel_q == sel_prev_q) && (seg_q == seg_prev_q);
    assign mask_set   = mask_q | sel_q;
    assign mask_full  = &mask_set;

    // Shared stability tracker: only one digit is ever being observed at a time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!sel_onehot) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StCounting;
                    cnt_d   = 8'd1;
                end
                StCounting: begin
                    if (!same) begin
                        cnt_d = 8'd1;
                    end else if (cnt_q == CntLast) begin
                        commit  = 1'b1;
                        cnt_d   = CntFull;
                        state_d = StLocked;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StLocked: begin
                    if (!same) begin
                        state_d = StCounting;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Segment letters ordered a..g, a in the MSB.
    assign letters = {seg_q[4], seg_q[5], seg_q[7], seg_q[3], seg_q[2], seg_q[1], seg_q[0]};

    always_comb begin
        dec_value = 4'h0;
        dec_blank = 1'b0;
        dec_error = 1'b0;
        case (letters)
            7'h7E: dec_value = 4'h0;
            7'h30: dec_value = 4'h1;
            7'h6D: dec_value = 4'h2;
            7'h79: dec_value = 4'h3;
            7'h33: dec_value = 4'h4;
            7'h5B: dec_value = 4'h5;
            7'h5F: dec_value = 4'h6;
            7'h70: dec_value = 4'h7;
            7'h7F: dec_value = 4'h8;
            7'h7B: dec_value = 4'h9;
            7'h77: dec_value = 4'hA;
            7'h1F: dec_value = 4'hB;
            7'h4E: dec_value = 4'hC;
            7'h3D: dec_value = 4'hD;
            7'h4F: dec_value = 4'hE;
            7'h47: dec_value = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_error = 1'b1;
        endcase
    end

    always_ff @(posedge input_clock1_1 or negedge input_reset_n_2) begin
        if (!input_reset_n_2) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sel_q      <= '0;
            seg_q      <= '0;
            sel_prev_q <= '0;
            seg_prev_q <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            dp_q       <= '0;
            valid_q    <= '0;
            blank_q    <= '0;
            error_q    <= '0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= input_digit_sel_4;
            seg_q      <= input_segments_3;
            sel_prev_q <= sel_q;
            seg_prev_q <= seg_q;
            frame_q    <= commit && mask_full;
            if (commit) begin
                // The completing commit is consumed by the pulse, so the mask restarts empty.
                mask_q <= mask_full ? '0 : mask_set;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        value_q[4*i +: 4] <= dec_value;
                        dp_q[i]           <= seg_q[6];
                        valid_q[i]        <= 1'b1;
                        blank_q[i]        <= dec_blank;
                        error_q[i]        <= dec_error;
                    end
                end
            end
        end
    end

    assign output_value_5  = value_q;
    assign output_dp_6     = dp_q;
    assign output_valid_7  = valid_q;
    assign output_blank_8  = blank_q;
    assign output_error_9  = error_q;
    assign output_frame_10 = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus randomized scanning
// checked against a pin-level model of stable runs and the hex letter table.
module tb_seg7_scan_decoder;

    localparam int ND = 3;
    localparam int SC = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      seg = '0;
    logic [ND-1:0]   sel = '0;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dp, valid, blank, error;
    logic            frame;

    int checks = 0;
    int errors = 0;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .input_clock1_1   (clk),
        .input_reset_n_2  (rst_n),
        .input_segments_3 (seg),
        .input_digit_sel_4(sel),
        .output_value_5   (value),
        .output_dp_6      (dp),
        .output_valid_7   (valid),
        .output_blank_8   (blank),
        .output_error_9   (error),
        .output_frame_10  (frame)
    );

    always #5 clk = ~clk;

    string hex_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                              "aefg"};

    // Reference model state
    logic [4*ND-1:0] e_value;
    logic [ND-1:0]   e_dp, e_valid, e_blank, e_error, e_mask;
    logic            e_frame;
    int              run;
    logic [ND-1:0]   last_sel;
    logic [7:0]      last_seg;
    bit              pend;
    int              pend_dig;
    logic [7:0]      pend_seg;

    // Letters a..g as a 7-bit set, a in the MSB.
    function automatic logic [6:0] letters(string s);
        logic [6:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
        return r;
    endfunction

    // Bus layout {c,dp,b,a,d,e,f,g}.
    function automatic logic [7:0] to_bus(logic [6:0] l, logic p);
        logic [7:0] b = '0;
        b[4] = l[6]; b[5] = l[5]; b[7] = l[4]; b[3] = l[3];
        b[2] = l[2]; b[1] = l[1]; b[0] = l[0]; b[6] = p;
        return b;
    endfunction

    function automatic int onehot_idx(logic [ND-1:0] s);
        if ($countones(s) != 1) return -1;
        for (int i = 0; i < ND; i++) if (s[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        e_value = '0; e_dp = '0; e_valid = '0; e_blank = '0; e_error = '0; e_mask = '0;
        e_frame = 1'b0; run = 0; last_sel = '0; last_seg = '0; pend = 0; pend_dig = 0;
        pend_seg = '0;
    endtask

    // Called right after a rising edge with the pin values that edge sampled.
    task automatic model_edge();
        logic [6:0] l;
        int         k;
        int         hv;
        e_frame = 1'b0;
        if (pend) begin
            l  = {pend_seg[4], pend_seg[5], pend_seg[7], pend_seg[3], pend_seg[2], pend_seg[1],
                  pend_seg[0]};
            hv = -1;
            for (int h = 0; h < 16; h++) if (letters(hex_names[h]) == l) hv = h;
            e_value[4*pend_dig +: 4] = (hv >= 0) ? 4'(hv) : 4'h0;
            e_blank[pend_dig] = (l == 7'h00);
            e_error[pend_dig] = (hv < 0) && (l != 7'h00);
            e_dp[pend_dig]    = pend_seg[6];
            e_valid[pend_dig] = 1'b1;
            e_mask[pend_dig]  = 1'b1;
            if (&e_mask) begin
                e_frame = 1'b1;
                e_mask  = '0;
            end
        end
        pend = 0;
        k = onehot_idx(sel);
        if (k < 0) begin
            run = 0;
        end else if (run > 0 && sel == last_sel && seg == last_seg) begin
            if (run < SC) begin
                run++;
                if (run == SC) begin
                    pend     = 1;
                    pend_dig = k;
                    pend_seg = seg;
                end
            end
        end else begin
            run = 1;
        end
        last_sel = sel;
        last_seg = seg;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(logic [ND-1:0] s, logic [7:0] b);
        sel = s;
        seg = b;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive('0, '0);
        assert_reset();
        #1;
        checks++;
        if ({value, dp, valid, blank, error, frame} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {value, dp, valid, blank, error, frame});
        end
        release_reset();
        step();
        checks++;
        if ({value, valid, frame} !== '0) begin
            errors++;
            $display("FAIL reset_release got %h want 0", {value, valid, frame});
        end
    endtask

    task automatic test_latency();
        drive(3'b001, to_bus(letters("abcdg"), 1'b0));
        for (int e = 1; e <= 10; e++) begin
            step();
            checks++;
            if (e < 5 && valid !== 3'b000) begin
                errors++;
                $display("FAIL latency_early edge %0d valid got %b want 000", e, valid);
            end else if (e >= 5 && (value[3:0] !== 4'h3 || valid !== 3'b001 || frame !== 1'b0)) begin
                errors++;
                $display("FAIL latency_commit edge %0d value %h valid %b frame %b want 3 001 0",
                         e, value[3:0], valid, frame);
            end
        end
    endtask

    task automatic test_short_run();
        drive(3'b010, to_bus(letters("adefg"), 1'b0));
        repeat (3) step();
        drive(3'b010, to_bus(letters("bc"), 1'b0));
        step();
        drive(3'b010, to_bus(letters("adefg"), 1'b0));
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (e < 5 && (valid[1] !== 1'b0 || value[7:4] !== 4'h0)) begin
                errors++;
                $display("FAIL short_run edge %0d valid1 %b value1 %h want 0 0", e, valid[1],
                         value[7:4]);
            end else if (e == 5 && (valid[1] !== 1'b1 || value[7:4] !== 4'hE)) begin
                errors++;
                $display("FAIL short_run_commit valid1 %b value1 %h want 1 e", valid[1],
                         value[7:4]);
            end
        end
    endtask

    task automatic test_frame();
        int pulses;
        int pulse_block;
        assert_reset();
        release_reset();
        for (int scan = 0; scan < 2; scan++) begin
            pulses      = 0;
            pulse_block = -1;
            for (int d = 0; d < ND; d++) begin
                drive(ND'(1 << d), to_bus(letters(hex_names[d + 5]), 1'b0));
                repeat (6) begin
                    step();
                    if (frame === 1'b1) begin
                        pulses++;
                        pulse_block = d;
                    end
                end
            end
            checks++;
            if (pulses != 1 || pulse_block != ND - 1) begin
                errors++;
                $display("FAIL frame_scan%0d pulses %0d in digit %0d want 1 in digit %0d", scan,
                         pulses, pulse_block, ND - 1);
            end
        end
        checks++;
        if (value !== 12'h765) begin
            errors++;
            $display("FAIL frame_values got %h want 765", value);
        end
    endtask

    task automatic test_bad_sel();
        for (int c = 0; c < 20; c++) begin
            drive((c < 10) ? 3'b011 : 3'b000, to_bus(letters("abc"), 1'b1));
            step();
            checks++;
            if ({value, dp, valid, blank, error, frame} !==
                {e_value, e_dp, e_valid, e_blank, e_error, e_frame} || frame !== 1'b0) begin
                errors++;
                $display("FAIL bad_sel cycle %0d got %h want %h", c,
                         {value, dp, valid, blank, error, frame},
                         {e_value, e_dp, e_valid, e_blank, e_error, e_frame});
            end
        end
    endtask

    task automatic test_blank_error();
        drive(3'b100, to_bus(7'h00, 1'b1));
        repeat (5) step();
        checks++;
        if (blank[2] !== 1'b1 || dp[2] !== 1'b1 || value[11:8] !== 4'h0 || error[2] !== 1'b0) begin
            errors++;
            $display("FAIL blank_digit blank %b dp %b value %h error %b want 1 1 0 0", blank[2],
                     dp[2], value[11:8], error[2]);
        end
        drive(3'b100, to_bus(letters("abg"), 1'b0));
        repeat (5) step();
        checks++;
        if (error[2] !== 1'b1 || blank[2] !== 1'b0 || dp[2] !== 1'b0 || value[11:8] !== 4'h0) begin
            errors++;
            $display("FAIL error_digit error %b blank %b dp %b value %h want 1 0 0 0", error[2],
                     blank[2], dp[2], value[11:8]);
        end
    endtask

    task automatic test_reset_mid();
        drive(3'b001, to_bus(letters("abc"), 1'b0));
        repeat (4) step();
        assert_reset();
        #1;
        checks++;
        if ({value, dp, valid, blank, error, frame} !== '0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", {value, dp, valid, blank, error, frame});
        end
        release_reset();
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (e < 5 && valid !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_early edge %0d valid %b want 000", e, valid);
            end else if (e == 5 && (valid !== 3'b001 || value[3:0] !== 4'h7)) begin
                errors++;
                $display("FAIL reset_mid_commit valid %b value %h want 001 7", valid, value[3:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [ND-1:0] s;
        logic [6:0]    l;
        int            r;
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            s = (r < 85) ? ND'(1 << $urandom_range(0, ND - 1)) : ND'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 70) l = letters(hex_names[$urandom_range(0, 15)]);
            else if (r < 80) l = 7'h00;
            else l = 7'($urandom);
            drive(s, to_bus(l, 1'($urandom)));
            repeat ($urandom_range(1, 7)) begin
                step();
                checks++;
                if ({value, dp, valid, blank, error, frame} !==
                    {e_value, e_dp, e_valid, e_blank, e_error, e_frame}) begin
                    errors++;
                    $display("FAIL random seq %0d got %h want %h", n,
                             {value, dp, valid, blank, error, frame},
                             {e_value, e_dp, e_valid, e_blank, e_error, e_frame});
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_latency();
        test_short_run();
        test_frame();
        test_bad_sel();
        test_blank_error();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
